// File: rtl/lsd_output_multibank_buffer.sv
// Multi-bank ring buffer for line segments: the detector fills one bank per frame,
// completed banks queue in FIFO order, and the PS claims/frees them with acquire/release.
module lsd_output_multibank_buffer #(
  parameter int FRAME_HEIGHT = 480,
  parameter int FRAME_WIDTH  = 640,
  parameter int RAM_SIZE     = 4096,
  parameter int NUM_BANKS    = 3,
  parameter bit SKIP_EMPTY   = 1'b1,
  localparam int V_BITW      = $clog2(FRAME_HEIGHT),
  localparam int H_BITW      = $clog2(FRAME_WIDTH),
  localparam int ADDR_BITW   = $clog2(RAM_SIZE),
  localparam int BANK_BITW   = $clog2(NUM_BANKS)
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 in_flag,
  input  logic                 in_valid,
  input  logic [V_BITW-1:0]    in_start_v,
  input  logic [H_BITW-1:0]    in_start_h,
  input  logic [V_BITW-1:0]    in_end_v,
  input  logic [H_BITW-1:0]    in_end_h,
  input  logic                 in_rd_acquire,
  input  logic                 in_rd_release,
  input  logic [ADDR_BITW-1:0] in_rd_addr,
  output logic                 out_ready,
  output logic                 out_busy,
  output logic [ADDR_BITW:0]   out_line_num,
  output logic                 out_overflow,
  output logic [15:0]          out_drop_cnt,
  output logic [V_BITW-1:0]    out_start_v,
  output logic [H_BITW-1:0]    out_start_h,
  output logic [V_BITW-1:0]    out_end_v,
  output logic [H_BITW-1:0]    out_end_h
);

  localparam int WORD_W = 2 * V_BITW + 2 * H_BITW;
  localparam logic [BANK_BITW-1:0] LAST_BANK = BANK_BITW'(NUM_BANKS - 1);

  logic [WORD_W-1:0]    ram [NUM_BANKS * RAM_SIZE];
  logic [WORD_W-1:0]    rd_data;
  logic                 flag_q;
  logic [BANK_BITW-1:0] wb, rb, wb_next, rb_next;
  logic [BANK_BITW:0]   ready_cnt, occupied;
  logic                 busy;
  logic [ADDR_BITW:0]   wr_addr;
  logic [ADDR_BITW:0]   cnt [NUM_BANKS];
  logic [NUM_BANKS-1:0] ovf;
  logic [15:0]          drop_cnt;
  logic                 frame_end, wr_en, bank_full, skip, room;
  logic                 do_commit, do_drop, do_acquire, do_release;

  // wr_addr saturates at RAM_SIZE, so its MSB alone marks a full bank
  assign frame_end  = flag_q && !in_flag;
  assign wr_en      = in_flag && in_valid;
  assign bank_full  = wr_addr[ADDR_BITW];
  assign occupied   = ready_cnt + {{BANK_BITW{1'b0}}, busy};
  assign skip       = SKIP_EMPTY && (wr_addr == '0);
  assign room       = occupied < (BANK_BITW + 1)'(NUM_BANKS - 1);
  assign do_commit  = frame_end && !skip && room;
  assign do_drop    = frame_end && !skip && !room;
  assign do_acquire = in_rd_acquire && out_ready;
  assign do_release = in_rd_release && busy;
  assign wb_next    = (wb == LAST_BANK) ? '0 : wb + 1'b1;
  assign rb_next    = (rb == LAST_BANK) ? '0 : rb + 1'b1;

  assign out_ready    = (ready_cnt != '0) && !busy;
  assign out_busy     = busy;
  assign out_line_num = busy ? cnt[rb] : '0;
  assign out_overflow = busy && ovf[rb];
  assign out_drop_cnt = drop_cnt;
  assign {out_start_v, out_start_h, out_end_v, out_end_h} = rd_data;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      flag_q    <= 1'b0;
      wb        <= '0;
      rb        <= '0;
      ready_cnt <= '0;
      busy      <= 1'b0;
      wr_addr   <= '0;
      ovf       <= '0;
      drop_cnt  <= '0;
      for (int i = 0; i < NUM_BANKS; i++) cnt[i] <= '0;
    end else begin
      flag_q <= in_flag;
      if (frame_end) begin
        wr_addr <= '0;
        if (do_commit) begin
          cnt[wb]      <= wr_addr;
          wb           <= wb_next;
          ovf[wb_next] <= 1'b0;
        end else begin
          ovf[wb] <= 1'b0;
        end
        if (do_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (wr_en) begin
        if (!bank_full) wr_addr <= wr_addr + 1'b1;
        else            ovf[wb] <= 1'b1;
      end
      if (do_commit && !do_acquire)      ready_cnt <= ready_cnt + 1'b1;
      else if (!do_commit && do_acquire) ready_cnt <= ready_cnt - 1'b1;
      // release always wins a same-cycle acquire because out_ready is low while busy
      if (do_acquire) begin
        busy <= 1'b1;
      end else if (do_release) begin
        busy <= 1'b0;
        rb   <= rb_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !bank_full)
      ram[{wb, wr_addr[ADDR_BITW-1:0]}] <= {in_start_v, in_start_h, in_end_v, in_end_h};
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) rd_data <= '0;
    else        rd_data <= ram[{rb, in_rd_addr}];
  end

endmodule
